// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller.
//               Provides the controller state encoding, the default memory
//               timeout and the register-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   localparam int REG_IDX_W       = 5;    // architectural register index width
   localparam int MEM_TIMEOUT_DEF = 255;  // default max consecutive MEM_WAIT cycles
   localparam int WAIT_CNT_W      = 8;    // width of the memory wait counter

   // Encoding 2'd3 is never entered; the controller decodes it as ST_ERR.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_det.sv
`default_nettype none
// ============================================================================
// Module      : load_use_det
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads a register that the load currently
//               in EX is going to write (x0 excluded).
// Ports       : id_rs1/id_rs2       - ID-stage source register indices
//               id_use_rs1/rs2      - ID instruction actually reads rs1/rs2
//               ex_rd               - EX-stage destination register index
//               ex_is_load          - EX instruction is a load
//               hazard              - load-use hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_det
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_load,
   output logic                 hazard
);

   logic rd_nonzero;
   logic rs1_match;
   logic rs2_match;

   assign rd_nonzero = (ex_rd != '0);
   assign rs1_match  = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_match  = id_use_rs2 && (id_rs2 == ex_rd);
   assign hazard     = ex_is_load && rd_nonzero && (rs1_match || rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard / stall controller for a 5-stage in-order pipeline.
//               Handles load-use stalls, taken-branch flushes, memory wait
//               stalls with timeout, and a sticky bus error state.
// Ports       : clk, rst_n (async, active low)
//               id_*, ex_*          - hazard sources from ID and EX
//               mem_req, mem_ack    - MEM stage handshake
//               *_en                - stage register enables
//               pc_sel_branch, if_id_flush, id_ex_bubble - redirect controls
//               bus_err, state_o    - error flag and current state
//               stall_cycles, flush_count - performance counters
// Config      : PIPE_HAZARD_CTRL_PERF_EN - when defined, builds saturating
//               performance counters; otherwise both counters read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_load,
   input  logic                 ex_branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ack,
   output logic                 pc_en,
   output logic                 if_id_en,
   output logic                 id_ex_en,
   output logic                 ex_mem_en,
   output logic                 mem_wb_en,
   output logic                 pc_sel_branch,
   output logic                 if_id_flush,
   output logic                 id_ex_bubble,
   output logic                 bus_err,
   output logic [1:0]           state_o,
   output logic [15:0]          stall_cycles,
   output logic [15:0]          flush_count
);

   localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W+1)'(MEM_TIMEOUT);

   state_t                state;
   state_t                state_nxt;
   logic                  flush_pend;
   logic                  flush_pend_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
   logic [WAIT_CNT_W:0]   wait_inc;
   logic                  timeout_hit;
   logic                  load_use;
   logic                  mem_stall;

   load_use_det u_load_use_det (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_is_load (ex_is_load),
      .hazard     (load_use)
   );

   assign mem_stall   = mem_req && !mem_ack;
   // Compare one bit wider so the count after this cycle can be checked
   // against the limit without the counter itself ever wrapping.
   assign wait_inc    = {1'b0, wait_cnt} + {{WAIT_CNT_W{1'b0}}, 1'b1};
   assign timeout_hit = (wait_inc >= TIMEOUT_LIM);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         flush_pend <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         flush_pend <= flush_pend_nxt;
         wait_cnt   <= wait_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      flush_pend_nxt = flush_pend;
      wait_cnt_nxt   = wait_cnt;
      case (state)
         ST_RUN: begin
            wait_cnt_nxt = '0;
            if (mem_stall) state_nxt = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_nxt      = ST_RUN;
               flush_pend_nxt = 1'b0;
               wait_cnt_nxt   = '0;
            end else begin
               // EX is frozen, so a branch seen now must be remembered
               // and applied once memory completes.
               flush_pend_nxt = flush_pend || ex_branch_taken;
               if (wait_cnt != '1) wait_cnt_nxt = wait_inc[WAIT_CNT_W-1:0];
               if (timeout_hit) state_nxt = ST_ERR;
            end
         end
         default: state_nxt = ST_ERR;  // ST_ERR and the unused encoding
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      if (rst_n) begin
         case (state)
            ST_RUN: begin
               if (!mem_stall) begin
                  pc_en     = 1'b1;
                  if_id_en  = 1'b1;
                  id_ex_en  = 1'b1;
                  ex_mem_en = 1'b1;
                  mem_wb_en = 1'b1;
                  if (ex_branch_taken) begin
                     pc_sel_branch = 1'b1;
                     if_id_flush   = 1'b1;
                     id_ex_bubble  = 1'b1;
                  end else if (load_use) begin
                     // The bubble moves the load on to MEM, so the hazard
                     // clears by itself after this single stall cycle.
                     pc_en        = 1'b0;
                     if_id_en     = 1'b0;
                     id_ex_bubble = 1'b1;
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack) begin
                  pc_en     = 1'b1;
                  if_id_en  = 1'b1;
                  id_ex_en  = 1'b1;
                  ex_mem_en = 1'b1;
                  mem_wb_en = 1'b1;
                  if (flush_pend || ex_branch_taken) begin
                     pc_sel_branch = 1'b1;
                     if_id_flush   = 1'b1;
                     id_ex_bubble  = 1'b1;
                  end
               end
            end
            default: ;  // error: pipeline frozen
         endcase
      end
   end

   assign bus_err = (state != ST_RUN) && (state != ST_MEM_WAIT);
   assign state_o = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_en && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
         if (if_id_flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances share
//               the stimulus: one with a short memory timeout (3) and one with
//               the default timeout. Both are compared every cycle against a
//               behavioural reference model.
// Config      : PIPE_HAZARD_CTRL_PERF_EN - selects expected counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
   logic       mem_req, mem_ack;

   logic [1:0] pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic [1:0] pc_sel_branch, if_id_flush, id_ex_bubble, bus_err;
   logic [1:0] st_o [2];
   logic [15:0] stall_o [2];
   logic [15:0] flush_o [2];

   pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .id_ex_en(id_ex_en[0]),
      .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
      .pc_sel_branch(pc_sel_branch[0]), .if_id_flush(if_id_flush[0]),
      .id_ex_bubble(id_ex_bubble[0]), .bus_err(bus_err[0]), .state_o(st_o[0]),
      .stall_cycles(stall_o[0]), .flush_count(flush_o[0])
   );

   pipe_hazard_ctrl u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .id_ex_en(id_ex_en[1]),
      .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
      .pc_sel_branch(pc_sel_branch[1]), .if_id_flush(if_id_flush[1]),
      .id_ex_bubble(id_ex_bubble[1]), .bus_err(bus_err[1]), .state_o(st_o[1]),
      .stall_cycles(stall_o[1]), .flush_count(flush_o[1])
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Control vector: {pc,if_id,id_ex,ex_mem,mem_wb enables, pc_sel, flush, bubble}
   localparam logic [7:0] CTL_RUN    = 8'b11111_000;
   localparam logic [7:0] CTL_BRANCH = 8'b11111_111;
   localparam logic [7:0] CTL_LOADUSE= 8'b00111_001;
   localparam logic [7:0] CTL_FROZEN = 8'b00000_000;

   int tmo [2] = '{3, 255};
   int m_mode [2];     // 0 running, 1 waiting on memory, 2 error
   int m_waits [2];
   int m_stall [2];
   int m_flush [2];
   bit m_pend [2];

   logic [7:0]  obs_ctl [2];
   logic [1:0]  obs_st [2];
   logic [15:0] obs_stall [2];
   logic [15:0] obs_flush [2];

   function automatic bit hazard_now();
      return ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   function automatic logic [7:0] exp_ctl(int k);
      if (m_mode[k] == 0) begin
         if (mem_req && !mem_ack) return CTL_FROZEN;
         if (ex_branch_taken)     return CTL_BRANCH;
         if (hazard_now())        return CTL_LOADUSE;
         return CTL_RUN;
      end
      if (m_mode[k] == 1) begin
         if (!mem_ack) return CTL_FROZEN;
         return (m_pend[k] || ex_branch_taken) ? CTL_BRANCH : CTL_RUN;
      end
      return CTL_FROZEN;
   endfunction

   function automatic logic [15:0] exp_cnt(int v);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      return 16'(v);
`else
      return 16'(v * 0);
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_waits[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_pend[k] = 0;
      end
   endtask

   function automatic logic [7:0] dut_ctl(int k);
      return {pc_en[k], if_id_en[k], id_ex_en[k], ex_mem_en[k], mem_wb_en[k],
              pc_sel_branch[k], if_id_flush[k], id_ex_bubble[k]};
   endfunction

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; ex_is_load = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic step();
      logic [7:0] e [2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e[k] = exp_ctl(k);
         obs_ctl[k] = dut_ctl(k); obs_st[k] = st_o[k];
         obs_stall[k] = stall_o[k]; obs_flush[k] = flush_o[k];
         check($sformatf("ctl[%0d]", k), 32'(obs_ctl[k]), 32'(e[k]));
         check($sformatf("state[%0d]", k), 32'(st_o[k]), 32'(m_mode[k]));
         check($sformatf("bus_err[%0d]", k), 32'(bus_err[k]), 32'(m_mode[k] == 2));
         check($sformatf("stall_cnt[%0d]", k), 32'(stall_o[k]), 32'(exp_cnt(m_stall[k])));
         check($sformatf("flush_cnt[%0d]", k), 32'(flush_o[k]), 32'(exp_cnt(m_flush[k])));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!e[k][7] && m_stall[k] < 65535) m_stall[k]++;
         if (e[k][1] && m_flush[k] < 65535)  m_flush[k]++;
         case (m_mode[k])
            0: if (mem_req && !mem_ack) begin m_mode[k] = 1; m_waits[k] = 0; end
            1: if (mem_ack) begin
                  m_mode[k] = 0; m_pend[k] = 0; m_waits[k] = 0;
               end else begin
                  m_pend[k] = m_pend[k] | ex_branch_taken;
                  m_waits[k]++;
                  if (m_waits[k] >= tmo[k]) m_mode[k] = 2;
               end
            default: ;
         endcase
      end
      #1;
   endtask

   // Asynchronous reset pulse spanning one rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_ctl[%0d]", k), 32'(dut_ctl(k)), 32'(CTL_FROZEN));
         check($sformatf("rst_state[%0d]", k), 32'(st_o[k]), 32'd0);
         check($sformatf("rst_bus_err[%0d]", k), 32'(bus_err[k]), 32'd0);
         check($sformatf("rst_cnt[%0d]", k), {stall_o[k], flush_o[k]}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      idle();
      do_reset();

      // Load-use stall, then its removal, then x0 destination
      ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      step();
      check("loaduse_ctl", 32'(obs_ctl[1]), 32'(CTL_LOADUSE));
      idle();
      step();
      check("loaduse_one_cycle", 32'(obs_ctl[1]), 32'(CTL_RUN));
      ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      step();
      check("loaduse_x0", 32'(obs_ctl[1]), 32'(CTL_RUN));

      // Branch outranks load-use
      ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1;
      step();
      check("branch_over_lu", 32'(obs_ctl[1]), 32'(CTL_BRANCH));

      // Memory wait with a branch in the 2nd wait cycle, ack after 4
      idle();
      do_reset();
      mem_req = 1;
      step();                                 // RUN stall cycle
      step();                                 // wait 1
      ex_branch_taken = 1; step();            // wait 2
      ex_branch_taken = 0; step(); step();    // waits 3, 4
      check("wait4_state", 32'(obs_st[1]), 32'd1);
      mem_ack = 1;
      step();
      check("ack_flush", 32'(obs_ctl[1]), 32'(CTL_BRANCH));
      idle();
      step();
      check("wait_stall_cnt", 32'(obs_stall[1]), 32'(exp_cnt(5)));
      check("wait_flush_cnt", 32'(obs_flush[1]), 32'(exp_cnt(1)));

      // Timeout into ERR (short-timeout instance)
      do_reset();
      mem_req = 1;
      repeat (4) step();
      idle();
      step();
      check("timeout_state", 32'(obs_st[0]), 32'd2);
      mem_ack = 1; mem_req = 1;
      repeat (3) step();
      check("err_sticky", 32'(obs_st[0]), 32'd2);
      idle();
      do_reset();
      step();
      check("err_cleared", 32'(obs_st[0]), 32'd0);

      // Reset in the middle of a wait with a pending flush
      mem_req = 1;
      step();
      ex_branch_taken = 1; step();
      ex_branch_taken = 0; step();
      idle();
      do_reset();
      mem_ack = 1;
      step();
      check("no_stale_flush", 32'(obs_ctl[1]), 32'(CTL_RUN));
      check("cnt_after_reset", 32'(obs_flush[1]), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         id_rs1 = 5'($urandom_range(0, 3));
         id_rs2 = 5'($urandom_range(0, 3));
         ex_rd  = 5'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         ex_is_load = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         mem_req = ($urandom_range(0, 3) == 0);
         mem_ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) do_reset();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
